// File: rtl/fft_addr_seq_if.sv
// Control and address bus between the FFT address sequencer and its surroundings
// (upstream control, FFT data memory, butterfly and twiddle ROM).
interface fft_addr_seq_if #(
    parameter int LOG2N = 12
);
    localparam int SW = $clog2(LOG2N + 1);
    localparam int LW = $clog2(LOG2N);

    logic             start;
    logic [SW-1:0]    log2_size;
    logic             stall;
    logic             busy;
    logic             done;
    logic [LW-1:0]    fft_level;
    logic [LOG2N-1:0] fft_raddra;
    logic [LOG2N-1:0] fft_raddrb;
    logic             fft_rd_valid;
    logic [LOG2N-2:0] twiddle_addr;
    logic [LOG2N-1:0] fft_waddra;
    logic [LOG2N-1:0] fft_waddrb;
    logic             fft_wea;
    logic             fft_web;
    logic             fft_data_valid;

    modport master (
        input  start, log2_size, stall,
        output busy, done, fft_level, fft_raddra, fft_raddrb, fft_rd_valid,
               twiddle_addr, fft_waddra, fft_waddrb, fft_wea, fft_web, fft_data_valid
    );

    modport slave (
        output start, log2_size, stall,
        input  busy, done, fft_level, fft_raddra, fft_raddrb, fft_rd_valid,
               twiddle_addr, fft_waddra, fft_waddrb, fft_wea, fft_web, fft_data_valid
    );
endinterface

// File: rtl/fft_addr_seq.sv
// In-place radix-2 FFT address sequencer: walks all levels of one run-time-sized
// transform, issuing read/twiddle addresses and write addresses delayed by the butterfly latency.
module fft_addr_seq #(
    parameter int LOG2N        = 12,
    parameter int BFLY_LATENCY = 7
) (
    input  logic           clk,
    input  logic           reset,
    fft_addr_seq_if.master bus
);
    localparam int SW  = $clog2(LOG2N + 1);
    localparam int LW  = $clog2(LOG2N);
    localparam int CW  = LOG2N - 1;
    localparam int LAT = BFLY_LATENCY;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    m_q, m_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic [LOG2N-1:0] wa_q [LAT];
    logic [LOG2N-1:0] wa_d [LAT];
    logic [LOG2N-1:0] wb_q [LAT];
    logic [LOG2N-1:0] wb_d [LAT];
    logic [LAT-1:0]   vld_q, vld_d;

    logic             rd_valid;
    logic [LOG2N-1:0] raddra, raddrb;
    logic [CW-1:0]    twiddle;
    logic [CW-1:0]    last_count;
    logic             drain_ok;
    int               m_i, l_i;

    function automatic logic [SW-1:0] clamp_size(input logic [SW-1:0] req);
        if (int'(req) < 2) return SW'(2);
        if (int'(req) > LOG2N) return SW'(LOG2N);
        return req;
    endfunction

    // Rotate left by l within the low m bits; bits at and above m stay zero.
    function automatic logic [LOG2N-1:0] rotl_m(input logic [LOG2N-1:0] v, input int m, input int l);
        logic [2*LOG2N-1:0] w;
        logic [LOG2N-1:0]   lo, hi;
        w  = {{LOG2N{1'b0}}, v} << l;
        lo = w[LOG2N-1:0] & ({LOG2N{1'b1}} >> (LOG2N - m));
        hi = LOG2N'(w >> m);
        return lo | hi;
    endfunction

    // Keep the top L bits of the (M-1)-bit count, then scale into the full-size ROM.
    function automatic logic [CW-1:0] twiddle_of(input logic [CW-1:0] cnt, input int m, input int l);
        logic [CW-1:0] low;
        low = {CW{1'b1}} >> (CW - (m - 1 - l));
        return (cnt & ~low) << (LOG2N - m);
    endfunction

    always_comb begin
        m_i        = int'(m_q);
        l_i        = int'(level_q);
        last_count = {CW{1'b1}} >> (CW - (m_i - 1));
        rd_valid   = 1'b0;
        raddra     = '0;
        raddrb     = '0;
        twiddle    = '0;
        if (state_q == RUN) begin
            raddra   = rotl_m({count_q, 1'b0}, m_i, l_i);
            raddrb   = rotl_m({count_q, 1'b1}, m_i, l_i);
            twiddle  = twiddle_of(count_q, m_i, l_i);
            rd_valid = !bus.stall;
        end
    end

    // Write pipeline shifts every cycle; stalled or idle cycles enter as bubbles.
    always_comb begin
        vld_d[0] = rd_valid;
        wa_d[0]  = raddra;
        wb_d[0]  = raddrb;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            wa_d[i]  = wa_q[i-1];
            wb_d[i]  = wb_q[i-1];
        end
    end

    // Pipeline is empty after this edge when only the last stage may still hold a write.
    always_comb begin
        drain_ok = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            if (vld_q[i]) drain_ok = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        level_d = level_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    m_d     = clamp_size(bus.log2_size);
                    level_d = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (count_q == last_count) begin
                        state_d = DRAIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    if (l_i == m_i - 1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        level_d = level_q + 1'b1;
                        count_d = '0;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= SW'(2);
            level_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            level_q <= level_d;
            count_q <= count_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
        end
    end

    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.fft_level      = level_q;
    assign bus.fft_raddra     = raddra;
    assign bus.fft_raddrb     = raddrb;
    assign bus.fft_rd_valid   = rd_valid;
    assign bus.twiddle_addr   = twiddle;
    assign bus.fft_waddra     = wa_q[LAT-1];
    assign bus.fft_waddrb     = wb_q[LAT-1];
    assign bus.fft_wea        = vld_q[LAT-1];
    assign bus.fft_web        = vld_q[LAT-1];
    assign bus.fft_data_valid = vld_q[LAT-1];
endmodule

// File: tb/tb_fft_addr_seq.sv
// Bench for fft_addr_seq: directed and random stimulus against a schedule-level
// behavioural model checked every cycle, plus literal address pins.
module tb_fft_addr_seq;
    localparam int LOG2N = 4;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_addr_seq_if #(.LOG2N(LOG2N)) bus ();
    fft_addr_seq #(.LOG2N(LOG2N), .BFLY_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rot(input int x, input int l, input int m);
        return ((x << l) | (x >> (m - l))) & ((1 << m) - 1);
    endfunction

    function automatic int clamp_m(input int s);
        if (s < 2) return 2;
        if (s > LOG2N) return LOG2N;
        return s;
    endfunction

    // Model: which butterfly is due, plus a countdown of drain cycles after each level.
    bit m_busy, m_done;
    int m_M, m_L, m_idx, m_wait;
    int h_a [LAT];
    int h_b [LAT];
    int h_v [LAT];
    int e_a, e_b, e_t, e_rd, k;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_busy",  int'(bus.busy), 0);
            chk("rst_done",  int'(bus.done), 0);
            chk("rst_level", int'(bus.fft_level), 0);
            chk("rst_rdv",   int'(bus.fft_rd_valid), 0);
            chk("rst_ra",    int'(bus.fft_raddra), 0);
            chk("rst_rb",    int'(bus.fft_raddrb), 0);
            chk("rst_tw",    int'(bus.twiddle_addr), 0);
            chk("rst_wa",    int'(bus.fft_waddra), 0);
            chk("rst_wb",    int'(bus.fft_waddrb), 0);
            chk("rst_wea",   int'(bus.fft_wea), 0);
            chk("rst_web",   int'(bus.fft_web), 0);
            chk("rst_dv",    int'(bus.fft_data_valid), 0);
            m_busy = 0; m_done = 0; m_M = 2; m_L = 0; m_idx = 0; m_wait = 0;
            for (int i = 0; i < LAT; i++) begin h_a[i] = 0; h_b[i] = 0; h_v[i] = 0; end
        end else begin
            e_a = 0; e_b = 0; e_t = 0; e_rd = 0;
            if (m_busy && m_wait == 0) begin
                k    = m_M - 1 - m_L;
                e_a  = rot(2 * m_idx, m_L, m_M);
                e_b  = rot(2 * m_idx + 1, m_L, m_M);
                e_t  = ((m_idx >> k) << k) << (LOG2N - m_M);
                e_rd = bus.stall ? 0 : 1;
            end
            chk("busy",  int'(bus.busy), int'(m_busy));
            chk("done",  int'(bus.done), int'(m_done));
            chk("level", int'(bus.fft_level), m_L);
            chk("rdv",   int'(bus.fft_rd_valid), e_rd);
            chk("ra",    int'(bus.fft_raddra), e_a);
            chk("rb",    int'(bus.fft_raddrb), e_b);
            chk("tw",    int'(bus.twiddle_addr), e_t);
            chk("wa",    int'(bus.fft_waddra), h_a[LAT-1]);
            chk("wb",    int'(bus.fft_waddrb), h_b[LAT-1]);
            chk("wea",   int'(bus.fft_wea), h_v[LAT-1]);
            chk("web",   int'(bus.fft_web), h_v[LAT-1]);
            chk("dv",    int'(bus.fft_data_valid), h_v[LAT-1]);
            if (e_rd == 1) begin
                if (m_M == 4 && m_L == 0 && m_idx == 7) begin
                    chk("pin_l0_a", int'(bus.fft_raddra), 14);
                    chk("pin_l0_b", int'(bus.fft_raddrb), 15);
                    chk("pin_l0_t", int'(bus.twiddle_addr), 0);
                end
                if (m_M == 4 && m_L == 1 && m_idx == 1) begin
                    chk("pin_l1_a", int'(bus.fft_raddra), 4);
                    chk("pin_l1_b", int'(bus.fft_raddrb), 6);
                end
                if (m_M == 4 && m_L == 3 && m_idx == 1) begin
                    chk("pin_l3_a", int'(bus.fft_raddra), 1);
                    chk("pin_l3_b", int'(bus.fft_raddrb), 9);
                    chk("pin_l3_t", int'(bus.twiddle_addr), 1);
                end
                if (m_M == 3 && m_L == 2 && m_idx == 3) begin
                    chk("pin_m3_a", int'(bus.fft_raddra), 3);
                    chk("pin_m3_b", int'(bus.fft_raddrb), 7);
                    chk("pin_m3_t", int'(bus.twiddle_addr), 6);
                end
            end
            for (int i = LAT - 1; i > 0; i--) begin
                h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1]; h_v[i] = h_v[i-1];
            end
            h_a[0] = e_a; h_b[0] = e_b; h_v[0] = e_rd;
            m_done = 0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1; m_M = clamp_m(int'(bus.log2_size));
                    m_L = 0; m_idx = 0; m_wait = 0;
                end
            end else if (m_wait == 0) begin
                if (!bus.stall) begin
                    if (m_idx == (1 << (m_M - 1)) - 1) m_wait = LAT;
                    else m_idx++;
                end
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    if (m_L == m_M - 1) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        m_L++; m_idx = 0;
                    end
                end
            end
        end
    end

    task automatic run_xfer(input int sz, input int stall_at, input int stall_len);
        int cyc;
        bus.log2_size = 3'(sz);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 500) begin
            if (cyc == stall_at) bus.stall = 1'b1;
            if (cyc == stall_at + stall_len) bus.stall = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        bus.stall = 1'b0;
        chk("xfer_end_busy", int'(bus.busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.log2_size = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_xfer(4, -1, 0);
        repeat (2) @(posedge clk);
        #1;
        run_xfer(4, 3, 5);
        run_xfer(3, -1, 0);
        run_xfer(0, -1, 0);
        run_xfer(7, -1, 0);

        bus.log2_size = 3'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.fft_level != 2'd1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_level1", int'(bus.fft_level), 1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_wea",  int'(bus.fft_wea), 0);
        chk("midrst_web",  int'(bus.fft_web), 0);
        chk("midrst_rdv",  int'(bus.fft_rd_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        run_xfer(4, -1, 0);

        for (int n = 0; n < 1500; n++) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.log2_size = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("final_idle", int'(bus.busy), 0);
        repeat (5) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
